// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the tx arbiter state encoding.
package uart_pkg;

  localparam int NB_DATA_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid index at or above the pointer,
// wrapping from N_REQ-1 back to 0.
module rr_picker #(
  parameter int N_REQ  = 3,
  parameter int NB_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]  i_valid,
  input  logic [NB_PTR-1:0] i_ptr,
  output logic              o_any_valid,
  output logic [NB_PTR-1:0] o_winner
);

  always_comb begin
    int idx;
    o_any_valid = |i_valid;
    o_winner    = i_ptr;
    idx         = 0;
    // Scan offsets from farthest to nearest so the nearest valid index is kept.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(i_ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (i_valid[idx]) begin
        o_winner = NB_PTR'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART tx serializer among N_REQ byte producers,
// one frame at a time, with a watchdog that releases a frame that never completes.
module tx_arbiter
  import uart_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEFAULT,
  parameter int N_REQ      = 3,
  parameter int NB_TIMEOUT = 18,
  parameter int TIMEOUT    = 200000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_done_tx,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int NB_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                state_q, state_d;
  logic [NB_PTR-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  logic                  timeout_s;
  logic                  pick_any_s;
  logic [NB_PTR-1:0]     pick_idx_s;

  rr_picker #(
    .N_REQ  (N_REQ),
    .NB_PTR (NB_PTR)
  ) u_rr_picker (
    .i_valid     (i_req_valid),
    .i_ptr       (rr_ptr_q),
    .o_any_valid (pick_any_s),
    .o_winner    (pick_idx_s)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    timeout_s   = 1'b0;
    o_req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          o_req_ready[pick_idx_s] = 1'b1;
          tx_data_d               = i_req_data[pick_idx_s*NB_DATA +: NB_DATA];
          grant_d                 = '0;
          grant_d[pick_idx_s]     = 1'b1;
          rr_ptr_d                = (int'(pick_idx_s) == N_REQ - 1) ? '0 : pick_idx_s + NB_PTR'(1);
          tx_start_d              = 1'b1;
          busy_d                  = 1'b1;
          state_d                 = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + NB_TIMEOUT'(1);
        // A done pulse on the final watchdog cycle is a normal completion.
        if (i_done_tx) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == NB_TIMEOUT'(TIMEOUT - 1)) begin
          timeout_s = 1'b1;
          state_d   = ST_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_s;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus random traffic,
// every cycle compared against a frame-age reference model.
module tb_tx_arbiter;

  localparam int NB = 8;
  localparam int N  = 3;
  localparam int T  = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid;
  logic [N*NB-1:0] data;
  logic          done;
  logic [N-1:0]  ready_o;
  logic [NB-1:0] tx_data_o;
  logic          tx_start_o;
  logic [N-1:0]  grant_o;
  logic          busy_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  tx_arbiter #(
    .NB_DATA    (NB),
    .N_REQ      (N),
    .NB_TIMEOUT (18),
    .TIMEOUT    (T)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_data  (data),
    .o_req_ready (ready_o),
    .o_tx_data   (tx_data_o),
    .o_tx_start  (tx_start_o),
    .i_done_tx   (done),
    .o_grant     (grant_o),
    .o_busy      (busy_o),
    .o_timeout   (timeout_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cur_cyc  = 0;

  // Reference model: age of the current frame in cycles since acceptance (-1 = no frame).
  int       m_age   = -1;
  int       m_ptr   = 0;
  int       m_owner = 0;
  logic [7:0] m_data = 8'h00;

  logic [N-1:0]  sticky = '0;
  logic [N-1:0]  obs_ready, obs_grant;
  logic          obs_start, obs_busy, obs_timeout;
  logic [NB-1:0] obs_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cur_cyc);
    end
  endtask

  task automatic set_byte(input int r, input logic [7:0] b);
    data[r*NB +: NB] = b;
  endtask

  task automatic cycle();
    int         win;
    bit         idle;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_grant;
    logic       fire;
    #1;
    cur_cyc     = cyc;
    obs_ready   = ready_o;
    obs_grant   = grant_o;
    obs_start   = tx_start_o;
    obs_busy    = busy_o;
    obs_timeout = timeout_o;
    obs_data    = tx_data_o;
    idle = (m_age < 0);
    win  = -1;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (m_ptr + i) % N;
      if (win < 0 && valid[idx]) win = idx;
    end
    exp_ready = (idle && win >= 0) ? (N'(1) << win) : '0;
    exp_grant = (m_age >= 1) ? (N'(1) << m_owner) : '0;
    fire      = (m_age == T + 1) && !done;
    check_eq("ready",    32'(obs_ready),   32'(exp_ready));
    check_eq("tx_start", 32'(obs_start),   32'(m_age == 1));
    check_eq("busy",     32'(obs_busy),    32'(m_age >= 1));
    check_eq("grant",    32'(obs_grant),   32'(exp_grant));
    check_eq("tx_data",  32'(obs_data),    32'(m_data));
    check_eq("timeout",  32'(obs_timeout), 32'(fire));
    if (rst) begin
      m_age = -1; m_ptr = 0; m_owner = 0; m_data = 8'h00;
    end else if (idle) begin
      if (win >= 0) begin
        m_age   = 1;
        m_owner = win;
        m_data  = data[win*NB +: NB];
        m_ptr   = (win + 1) % N;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (done || m_age == T + 1) begin
      m_age = -1;
    end else begin
      m_age++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int r = 0; r < N; r++) begin
      if (obs_ready[r] && !sticky[r]) valid[r] = 1'b0;
    end
  endtask

  task automatic wait_start(input string tag, output int s);
    bit found;
    found = 1'b0;
    s     = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (obs_start) begin
        found = 1'b1;
        s     = cur_cyc;
      end
    end
    if (!found) check_eq(tag, 32'(obs_start), 32'd1);
  endtask

  task automatic finish_frame();
    cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int s;
    int t;
    rst   = 1'b1;
    valid = '0;
    data  = '0;
    done  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pulse_reset();
    check_eq("rst_grant", 32'(obs_grant), 32'd0);
    check_eq("rst_busy",  32'(obs_busy),  32'd0);

    // Single request from requester 1, done 20 cycles after start.
    set_byte(1, 8'h41);
    valid[1] = 1'b1;
    wait_start("s1_start", s);
    check_eq("s1_data",  32'(obs_data),  32'h41);
    check_eq("s1_grant", 32'(obs_grant), 32'b010);
    while (cyc < s + 20) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    cycle();
    check_eq("s1_idle_busy",  32'(obs_busy),  32'd0);
    check_eq("s1_idle_grant", 32'(obs_grant), 32'd0);

    // All three continuously valid: grant order 0,1,2,0,1,2.
    pulse_reset();
    set_byte(0, 8'hA0); set_byte(1, 8'hA1); set_byte(2, 8'hA2);
    sticky = 3'b111;
    valid  = 3'b111;
    for (int f = 0; f < 6; f++) begin
      wait_start("rr_start", s);
      check_eq("rr_grant", 32'(obs_grant), 32'(3'b001 << (f % 3)));
      check_eq("rr_data",  32'(obs_data),  32'(8'hA0 + 8'(f % 3)));
      cycle();
      finish_frame();
      if (f == 5) begin
        sticky = 3'b000;
        valid  = 3'b101;
      end
    end

    // Wrap after last grant 2: requesters 0 and 2 -> 0 then 2.
    wait_start("wrap_start0", s);
    check_eq("wrap_first", 32'(obs_grant), 32'b001);
    finish_frame();
    wait_start("wrap_start2", s);
    check_eq("wrap_second", 32'(obs_grant), 32'b100);
    finish_frame();

    // Watchdog: no done, requester 2 pending behind the stuck frame.
    set_byte(1, 8'h55);
    valid[1] = 1'b1;
    wait_start("wd_start", s);
    set_byte(2, 8'h66);
    valid[2] = 1'b1;
    t = -1;
    while (t < 0 && cyc <= s + T + 3) begin
      cycle();
      if (obs_timeout) t = cur_cyc;
    end
    check_eq("wd_at", 32'(t - s), 32'(T));
    cycle();
    check_eq("wd_regrant", 32'(obs_ready), 32'b100);
    wait_start("wd_next_start", s);
    finish_frame();

    // Done on the last watchdog cycle wins over the timeout.
    set_byte(0, 8'h3C);
    valid[0] = 1'b1;
    wait_start("co_start", s);
    while (cyc < s + T) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    check_eq("co_timeout", 32'(obs_timeout), 32'd0);
    cycle();
    check_eq("co_idle", 32'(obs_busy), 32'd0);

    // Reset in the middle of WAIT, with a done pulse during the reset cycle.
    set_byte(1, 8'h77);
    valid[1] = 1'b1;
    wait_start("mr_start", s);
    cycle(); cycle(); cycle();
    set_byte(0, 8'h10);
    rst   = 1'b1;
    done  = 1'b1;
    valid = 3'b011;
    cycle();
    rst  = 1'b0;
    done = 1'b0;
    cycle();
    check_eq("mr_grant", 32'(obs_grant), 32'd0);
    check_eq("mr_busy",  32'(obs_busy),  32'd0);
    check_eq("mr_data",  32'(obs_data),  32'd0);
    check_eq("mr_start", 32'(obs_start), 32'd0);
    check_eq("mr_ready", 32'(obs_ready), 32'b001);
    wait_start("mr_next", s);
    check_eq("mr_winner", 32'(obs_grant), 32'b001);
    finish_frame();
    wait_start("mr_next1", s);
    finish_frame();

    // Random traffic with random done pulses and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom % 300) == 0;
      done = ($urandom % 8) == 0;
      for (int r = 0; r < N; r++) begin
        if (!valid[r] && ($urandom % 3) == 0) begin
          set_byte(r, 8'($urandom));
          valid[r] = 1'b1;
        end
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
